// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the mips_cpu_bus Avalon-MM arbiter.
//   bus_state_t : arbiter FSM state encoding
//   grant_t     : which requester currently owns the master port
//   BE_WORD     : full-word byte enable used for instruction fetches
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter_wait_timer.sv
// Saturating waitrequest counter for the bus arbiter.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clr_i       : force the count to zero (held while not on the bus)
//   en_i        : count this cycle (bus cycle with waitrequest high)
//   expired_o   : this enabled cycle is the TIMEOUT_CYCLES-th stalled cycle;
//                 never asserts when TIMEOUT_CYCLES is 0
module wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag on the last allowed stalled cycle, so the abort edge is the one at
    // which the count would reach TIMEOUT_CYCLES; the strobe is then high for
    // exactly TIMEOUT_CYCLES cycles.
    assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (count_q >= LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the single Avalon-MM master port of mips_cpu_bus between the
// instruction-fetch and data load/store requesters.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   i_req/i_addr -> i_done/i_rdata     : fetch level request, done pulse + word
//   d_req/d_write/d_addr/d_wdata/
//   d_byteenable -> d_done/d_rdata     : data level request, done pulse + word
//   address/read/write/writedata/
//   byteenable, waitrequest/readdata   : Avalon-MM master
//   busy                               : FSM not in IDLE
//   timeout_err                        : sticky, set on any aborted access
//
// state | meaning
// IDLE  | no access; arbitrate requests, latch the winner
// BUS   | strobe driven from latched values, waiting for !waitrequest
// DONE  | one-cycle done pulse to the granted requester
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        timeout_err
);

    bus_state_t  state_q;
    grant_t      last_grant_q;   // also identifies the owner of the current access
    logic [31:0] address_q, writedata_q, i_rdata_q, d_rdata_q;
    logic [3:0]  byteenable_q;
    logic        read_q, write_q, i_done_q, d_done_q, timeout_err_q;
    logic        expired;
    logic        grant_data;

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != BUS),
        .en_i      ((state_q == BUS) && waitrequest),
        .expired_o (expired)
    );

    // On a tie the requester that did not win last time gets the port.
    assign grant_data = d_req && (!i_req || (last_grant_q == FETCH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_grant_q  <= FETCH;
            address_q     <= '0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        state_q      <= BUS;
                        last_grant_q <= DATA;
                        address_q    <= d_addr;
                        writedata_q  <= d_wdata;
                        byteenable_q <= d_byteenable;
                        read_q       <= !d_write;
                        write_q      <= d_write;
                    end else if (i_req) begin
                        state_q      <= BUS;
                        last_grant_q <= FETCH;
                        address_q    <= i_addr;
                        writedata_q  <= '0;
                        byteenable_q <= BE_WORD;
                        read_q       <= 1'b1;
                        write_q      <= 1'b0;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        state_q <= DONE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (last_grant_q == FETCH) begin
                            i_done_q <= 1'b1;
                            if (read_q) i_rdata_q <= readdata;
                        end else begin
                            d_done_q <= 1'b1;
                            if (read_q) d_rdata_q <= readdata;
                        end
                    end else if (expired) begin
                        state_q       <= DONE;
                        read_q        <= 1'b0;
                        write_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        if (last_grant_q == FETCH) begin
                            i_done_q  <= 1'b1;
                            i_rdata_q <= '0;
                        end else begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Sequences and shares the single Avalon-MM master port of `mips_cpu_bus` between two requesters: the instruction-fetch path and the data load/store path. Each requester uses a level req / one-cycle done handshake. The arbiter grants one requester at a time and drives the Avalon address/read/write/byteenable signals. It holds them stable under `waitrequest`, captures `readdata`, and aborts stalled transfers after a programmable timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: number of waitrequest-high cycles allowed before an access is aborted; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request, level, held until `i_done`.
- `i_addr`  in  32  fetch byte address.
- `i_done`  out  1  one-cycle completion pulse for fetch.
- `i_rdata`  out  32  fetched word, valid while `i_done`=1.
- `d_req`  in  1  data request, level, held until `d_done`.
- `d_write`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_byteenable`  in  4  store/load lane enables.
- `d_done`  out  1  one-cycle completion pulse for data.
- `d_rdata`  out  32  load word, valid while `d_done`=1.
- `address`  out  32  Avalon address.
- `read`  out  1  Avalon read strobe.
- `write`  out  1  Avalon write strobe.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte enables.
- `waitrequest`  in  1  Avalon stall.
- `readdata`  in  32  Avalon read data, valid in the cycle `read`=1 and `waitrequest`=0.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set on any aborted access.

## Operation
- FSM states are IDLE, BUS and DONE. `reset` low forces IDLE, `last_grant`=FETCH, clears `timeout_err`, and clears all outputs and data registers to 0.
- Arbitration happens in IDLE only:
  - Only `d_req` set: grant DATA.
  - Only `i_req` set: grant FETCH.
  - Both set: grant the requester not in `last_grant` (round-robin). After reset, DATA therefore wins the first tie.
- The granted request's address, direction, wdata and byteenable are latched at the grant edge. Requester inputs are ignored until the next IDLE.
- IDLE -> BUS on a grant. `last_grant` is updated at the same edge.
- In BUS, outputs are driven from the latched values:
  - FETCH: `read`=1, `write`=0, `byteenable`=4'b1111, `writedata`=0.
  - DATA: `read`=!d_write, `write`=d_write.
  - Outputs stay constant while `waitrequest`=1.
- BUS -> DONE when `waitrequest`=0. For reads, `readdata` is captured into the granted requester's rdata register at that edge.
- DONE lasts exactly one cycle and pulses the granted requester's done signal. It then goes to IDLE, and new requests are arbitrated there.
- A requester must drop req in its done cycle, or hold it to request another access. A held req is re-arbitrated as a new access.
- Timeout: a wait counter clears on entry to BUS and increments on each BUS cycle with `waitrequest`=1. When the counter reaches `TIMEOUT_CYCLES` (nonzero), the FSM goes to DONE. On that abort `read`/`write` drop, rdata is set to 0, and `timeout_err` is set. The counter saturates and does not wrap.
- The non-granted requester's rdata register is unchanged. Each done output is 0 outside DONE.
- Addresses pass through unmodified, with no alignment checks.

## Timing
- Zero-wait access: req sampled at edge 0; BUS in cycle 1 with the strobe high; DONE in cycle 2; IDLE in cycle 3.
- Load-to-done latency is 2 cycles plus the number of waitrequest-high cycles.
- Peak throughput: one access per 3 cycles.
- Strobe, address and data are registered outputs with no combinational path from req to Avalon.
- Timeout path: the strobe is high for exactly `TIMEOUT_CYCLES` cycles, then done pulses in the next cycle.
- Reset asserted mid-BUS drops `read`/`write` immediately (asynchronously). No done pulse is produced for the killed access.

## Structure
- Package `mips_bus_pkg`:
  - `bus_state_t` enum {IDLE, BUS, DONE}.
  - `grant_t` {FETCH, DATA}.
  - `BE_WORD` = 4'b1111.
- One sub-module, `wait_timer`: a saturating counter with clear/enable and `expired` output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- `i_req`, `i_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x8C220004 -> `read`=1 at address 0xBFC00000 with `byteenable`=F in cycle 1; `i_done`=1 with `i_rdata`=0x8C220004 in cycle 2.
- Store `d_addr`=0x1000, `d_wdata`=0xDEADBEEF, `d_byteenable`=0x3, `waitrequest` high 3 cycles -> `write`, `address`, `writedata` and `byteenable` stable for 4 cycles; `d_done` in cycle 5.
- Both requests held continuously after reset -> grants in the order DATA, FETCH, DATA, FETCH; done pulses alternate every 3 cycles.
- `TIMEOUT_CYCLES`=4, `waitrequest` stuck high -> `read` high 4 cycles then low; `i_done`=1 with `i_rdata`=0; `timeout_err`=1 until reset.
- `reset` pulsed low during BUS with `waitrequest`=1 -> `read`/`write`/`busy` 0 immediately, no done pulse; next tie after release grants DATA.
